// File: rtl/enemy_pkg.sv
// Shared types and constants for the enemy group datapath.
package enemy_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_MOVE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Horizontal direction encoding
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // 3-bit RGB colours
  localparam logic [2:0] COLOUR_BLACK = 3'b000;
  localparam logic [2:0] COLOUR_RED   = 3'b100;
  localparam logic [2:0] COLOUR_GREEN = 3'b010;
  localparam logic [2:0] COLOUR_BLUE  = 3'b001;
  localparam logic [2:0] COLOUR_WHITE = 3'b111;

  // Default 160x120 screen limits
  localparam int SCREEN_LEFT   = 0;
  localparam int SCREEN_RIGHT  = 159;
  localparam int SCREEN_TOP    = 0;
  localparam int SCREEN_BOTTOM = 119;

endpackage

// File: rtl/enemy_group_datapath_step.sv
// Next-position calculator for one enemy: step toward the current
// direction, then wrap or bounce once the limit is closer than one step.
module enemy_step_calc
  import enemy_pkg::*;
#(
  parameter int X_W = 8
) (
  input  logic [X_W-1:0] x,
  input  logic           dir,
  input  logic [2:0]     step,
  input  logic           bounce,
  input  logic [X_W-1:0] left_limit,
  input  logic [X_W-1:0] right_limit,
  output logic [X_W-1:0] next_x,
  output logic           next_dir
);

  logic [X_W-1:0] step_w;
  logic [X_W-1:0] dist_left;
  logic [X_W-1:0] dist_right;

  // Unsigned distances to each limit avoid any signed underflow
  always_comb begin
    step_w     = X_W'(step);
    dist_left  = x - left_limit;
    dist_right = right_limit - x;
    next_x     = x;
    next_dir   = dir;
    if (dir == DIR_LEFT) begin
      if (dist_left >= step_w) begin
        next_x = x - step_w;
      end else if (bounce) begin
        next_x   = left_limit;
        next_dir = DIR_RIGHT;
      end else begin
        next_x = right_limit;
      end
    end else begin
      if (dist_right >= step_w) begin
        next_x = x + step_w;
      end else if (bounce) begin
        next_x   = right_limit;
        next_dir = DIR_LEFT;
      end else begin
        next_x = left_limit;
      end
    end
  end

endmodule

// File: rtl/enemy_group_datapath.sv
// Enemy row datapath: waits TICK_DIV cycles per tick while update is held,
// then steps each enemy in turn (one per cycle) and pulses done.
module enemy_group_datapath
  import enemy_pkg::*;
#(
  parameter int           NUM_ENEMIES = 4,
  parameter int           TICK_DIV    = 250000,
  parameter int           X_W         = 8,
  parameter int           Y_W         = 7,
  parameter int           LEFT_LIMIT  = SCREEN_LEFT,
  parameter int           RIGHT_LIMIT = SCREEN_RIGHT,
  parameter int           START_X     = 140,
  parameter int           X_SPACING   = 10,
  parameter int           START_Y     = 10,
  parameter int           Y_SPACING   = 8,
  parameter logic [2:0]   COLOUR      = COLOUR_RED
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       update,
  input  logic                       bounce,
  input  logic [1:0]                 speed,
  input  logic [NUM_ENEMIES-1:0]     active,
  output logic                       done,
  output logic [NUM_ENEMIES*X_W-1:0] enemy_x,
  output logic [NUM_ENEMIES*Y_W-1:0] enemy_y,
  output logic [NUM_ENEMIES-1:0]     enemy_dir,
  output logic [2:0]                 colour
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENEMIES - 1);
  localparam logic [X_W-1:0]   LEFT_X   = X_W'(LEFT_LIMIT);
  localparam logic [X_W-1:0]   RIGHT_X  = X_W'(RIGHT_LIMIT);

  function automatic logic [X_W-1:0] start_x(input int i);
    return X_W'(START_X - i * X_SPACING);
  endfunction

  state_t                             state_q, state_d;
  logic   [CNT_W-1:0]                 cnt_q;
  logic   [IDX_W-1:0]                 idx_q;
  logic                               done_q;
  logic   [NUM_ENEMIES-1:0][X_W-1:0]  x_q;
  logic   [NUM_ENEMIES-1:0]           dir_q;

  logic                               clear;
  logic   [2:0]                       step;
  logic   [X_W-1:0]                   sel_x, next_x;
  logic                               sel_dir, next_dir;

  assign clear = reset | restart;
  assign step  = {1'b0, speed} + 3'd1;

  // One shared step calculator, fed by the enemy currently being moved
  assign sel_x   = x_q[idx_q];
  assign sel_dir = dir_q[idx_q];

  enemy_step_calc #(.X_W(X_W)) u_step (
    .x           (sel_x),
    .dir         (sel_dir),
    .step        (step),
    .bounce      (bounce),
    .left_limit  (LEFT_X),
    .right_limit (RIGHT_X),
    .next_x      (next_x),
    .next_dir    (next_dir)
  );

  // Next-state logic; dropping update only aborts the tick wait, never a sweep
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (update) state_d = S_COUNT;
      S_COUNT: begin
        if (!update)                state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_MOVE;
      end
      S_MOVE:  if (idx_q == IDX_LAST) state_d = S_DONE;
      S_DONE:  state_d = update ? S_COUNT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers: state, tick counter, sweep index, done pulse
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == S_DONE);
      if (state_q == S_COUNT && state_d == S_COUNT) cnt_q <= cnt_q + 1'b1;
      else                                          cnt_q <= '0;
      if (state_q == S_MOVE) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Enemy position/direction registers; only the indexed, active enemy moves
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_ENEMIES; i++) x_q[i] <= start_x(i);
      dir_q <= '0;
    end else if (state_q == S_MOVE && active[idx_q]) begin
      x_q[idx_q]   <= next_x;
      dir_q[idx_q] <= next_dir;
    end
  end

  // Rows sit at fixed heights
  for (genvar g = 0; g < NUM_ENEMIES; g++) begin : g_y
    assign enemy_y[g*Y_W +: Y_W] = Y_W'(START_Y + g * Y_SPACING);
  end

  assign enemy_x   = x_q;
  assign enemy_dir = dir_q;
  assign done      = done_q;
  assign colour    = COLOUR;

endmodule

// File: doc/enemy_group_datapath.md
# enemy_group_datapath

Parametrised enemy-row datapath: holds positions of `NUM_ENEMIES` sprites, advances them horizontally on a divided tick while the control FSM holds `update` high, and pulses `done` once every enemy has been stepped so the draw controller can erase and redraw. It supports wrap and bounce modes, a programmable step size and a per-enemy active mask. It sits between the game control FSM and the VGA draw datapath and replaces the single-enemy datapath.

## Interface
- `NUM_ENEMIES`, 4: enemies in the group.
- `TICK_DIV`, 250000: clock cycles per movement tick; must be ≥2.
- `X_W`, 8 / `Y_W`, 7: coordinate widths.
- `LEFT_LIMIT`, 0 / `RIGHT_LIMIT`, 159: inclusive x bounds.
- `START_X`, 140 / `X_SPACING`, 10: enemy i resets to x = START_X − i·X_SPACING, which must be ≥ LEFT_LIMIT.
- `START_Y`, 10 / `Y_SPACING`, 8: enemy i has fixed y = START_Y + i·Y_SPACING.
- `COLOUR`, 3'b100: sprite colour.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `restart` in 1: game restart (space key); same effect as reset.
- `update` in 1: level request from the control FSM.
- `bounce` in 1: 0 = wrap mode, 1 = bounce mode.
- `speed` in 2: step = speed+1 pixels (1..4).
- `active` in NUM_ENEMIES: bit i = 1 lets enemy i move.
- `done` out 1: one-cycle pulse after a full sweep.
- `enemy_x` out NUM_ENEMIES·X_W: packed; enemy i occupies bits [i·X_W +: X_W].
- `enemy_y` out NUM_ENEMIES·Y_W: packed the same way.
- `enemy_dir` out NUM_ENEMIES: 0 = moving left, 1 = moving right.
- `colour` out 3: constant COLOUR.

## Operation
- **Reset / restart** (reset has priority; restart has the same effect):
  - x and y go to their start values.
  - `enemy_dir` = 0.
  - The tick counter and sweep index clear.
  - State = IDLE; `done` = 0.
- **FSM states:**
  - IDLE: go to COUNT when `update` = 1.
  - COUNT: the counter increments each cycle. At TICK_DIV−1 the counter clears and the FSM goes to MOVE. If `update` = 0, the counter clears and the FSM returns to IDLE.
  - MOVE: updates enemy `idx` (0..N−1), one per cycle, then goes to DONE.
  - DONE: `done` = 1 for this cycle. Go to COUNT if `update` = 1, otherwise IDLE.
- Dropping `update` during MOVE does not abort the sweep; the sweep completes and `done` still pulses.
- **Step rule** for enemy i with step s, applied only if `active[i]` = 1. Comparisons use unsigned distance to the limit; there is no signed underflow.
  - Moving left, x − LEFT_LIMIT ≥ s: x −= s.
  - Moving left, x − LEFT_LIMIT < s: wrap mode sets x = RIGHT_LIMIT. Bounce mode sets x = LEFT_LIMIT and dir = 1.
  - Moving right, RIGHT_LIMIT − x ≥ s: x += s.
  - Moving right, RIGHT_LIMIT − x < s: wrap mode sets x = LEFT_LIMIT. Bounce mode sets x = RIGHT_LIMIT and dir = 0.
- Inactive enemies keep their x and dir unchanged.
- `bounce` and `speed` are sampled in the MOVE cycle of each enemy.
- `enemy_y` never changes after reset.

## Timing
- All outputs are registered. Reset values are listed above; `colour` is constant.
- Steady state: `done` pulses every TICK_DIV + NUM_ENEMIES + 1 cycles while `update` is held high.
- Latency: if `update` rises in cycle 0 (IDLE), `done` is high in cycle TICK_DIV + NUM_ENEMIES + 1.
- Enemy i's new x is visible the cycle after its MOVE slot. All x values are final when `done` = 1.
- Reset or restart in any state, including mid-MOVE, takes effect on the next edge. A sweep that is partly done is discarded.

## Structure
- Shared package `enemy_pkg` holds:
  - the FSM state enum (IDLE, COUNT, MOVE, DONE);
  - direction constants DIR_LEFT and DIR_RIGHT;
  - colour constants;
  - default screen limits.
- One natural sub-module, `enemy_step_calc`: combinational next-x / next-dir logic from (x, dir, step, bounce, limits). Instantiated once and muxed by `idx`.

## Test plan
Bench parameters: TICK_DIV = 4, NUM_ENEMIES = 4, defaults otherwise.
1. Assert `reset` for 1 cycle → x = 140/130/120/110, y = 10/18/26/34, `dir` = 0, `done` = 0.
2. `update` held high, speed = 0, wrap, active = 4'hF → `done` in cycle 9, then every 9 cycles. After the first pulse, x = 139/129/119/109.
3. Instance with START_X = 1, speed = 1, wrap → enemy 0 goes from x = 1 to x = 159. With bounce = 1 and START_X = 2, speed = 3 → x = 0, dir = 1; the next tick gives x = 4.
4. Drop `update` in cycle 2 of COUNT → return to IDLE with no `done`; re-raising `update` needs a full TICK_DIV again. Drop it during MOVE → the sweep completes and `done` pulses once.
5. active = 4'b0101 → only enemies 0 and 2 move; enemies 1 and 3 stay at 130 and 110.
6. `restart` pulse during MOVE (idx = 2) → the next cycle shows start positions, `done` = 0, state IDLE.
